// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer that shares the
// single-port data memory between the CPU MEM stage and the DMA loader.
// Each granted access spends WAIT_CYCLES+1 cycles in ACCESS and one cycle in
// DONE, where the owner's completion pulse is raised.
module dmem_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   // CPU port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_done,
   output logic              cpu_stall,
   // DMA port
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_done,
   // shared read data
   output logic [DATA_W-1:0] rdata,
   // memory side
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   typedef enum logic {
      OWN_CPU,
      OWN_DMA
   } owner_t;

   localparam logic [7:0] LP_WAIT = 8'(WAIT_CYCLES);

   state_t              r_state;
   state_t              w_next_state;
   owner_t              r_owner;
   owner_t              r_last_owner;
   owner_t              w_grant_owner;
   logic                w_any_req;
   logic                w_last_access;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [7:0]          r_cnt;

   // Round-robin pick: a tie goes to the port that did not own the last access
   always_comb begin
      w_any_req     = cpu_req | dma_req;
      w_grant_owner = OWN_CPU;
      if (dma_req && (!cpu_req || (r_last_owner == OWN_CPU))) begin
         w_grant_owner = OWN_DMA;
      end
      w_last_access = (r_state == S_ACCESS) && (r_cnt == '0);
   end

   // State register; reset aborts any access in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_next_state = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (w_last_access) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Latch the granted request, run the wait counter, capture read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner      <= OWN_DMA;
         r_last_owner <= OWN_DMA;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_grant_owner;
                  r_cnt   <= LP_WAIT;
                  if (w_grant_owner == OWN_DMA) begin
                     r_we    <= dma_we;
                     r_addr  <= dma_addr;
                     r_wdata <= dma_wdata;
                  end else begin
                     r_we    <= cpu_we;
                     r_addr  <= cpu_addr;
                     r_wdata <= cpu_wdata;
                  end
               end
            end
            S_ACCESS: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else begin
                  r_rdata <= mem_rdata;
               end
            end
            S_DONE: begin
               r_last_owner <= r_owner;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   // Outputs decoded from state; the write strobe fires only on the final ACCESS cycle
   always_comb begin
      mem_we    = w_last_access & r_we;
      cpu_done  = (r_state == S_DONE) && (r_owner == OWN_CPU);
      dma_done  = (r_state == S_DONE) && (r_owner == OWN_DMA);
      busy      = (r_state != S_IDLE);
      cpu_stall = cpu_req & ~cpu_done;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      rdata     = r_rdata;
   end

endmodule
